// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the L2 cache controller and its debug monitors
package rv32i_types;

    typedef enum logic [1:0] {
        L2_IDLE      = 2'd0,
        L2_WRITEBACK = 2'd1,
        L2_ALLOCATE  = 2'd2
    } l2_ctrl_state_t;

    // Dirty bit of the way the LRU logic has picked as the victim
    function automatic logic victim_dirty(input logic [3:0] dirty, input logic [1:0] lru);
        return dirty[lru];
    endfunction

endpackage

// File: rtl/l2_cache_control_if.sv
// rtl/l2_cache_control_if.sv - arbiter, datapath and memory handshake bundle for the L2 controller
interface l2_cache_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       hit_any;
    logic       dirty0_out;
    logic       dirty1_out;
    logic       dirty2_out;
    logic       dirty3_out;
    logic [1:0] lru_out;
    logic       idling;
    logic       alloc;
    logic       w_back;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;

    // Controller side
    modport master (
        input  mem_read, mem_write, hit_any,
        input  dirty0_out, dirty1_out, dirty2_out, dirty3_out, lru_out,
        input  pmem_resp,
        output mem_resp, idling, alloc, w_back, pmem_read, pmem_write
    );

    // Arbiter / datapath / memory side
    modport slave (
        output mem_read, mem_write, hit_any,
        output dirty0_out, dirty1_out, dirty2_out, dirty3_out, lru_out,
        output pmem_resp,
        input  mem_resp, idling, alloc, w_back, pmem_read, pmem_write
    );
endinterface

// File: rtl/l2_cache_control_perf_counters.sv
// rtl/l2_cache_control_perf_counters.sv - saturating hit/miss/writeback counters (L2_PERF_CNT_EN only)
module l2_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resp_evt_i,
    input  logic        miss_evt_i,
    input  logic        wb_evt_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o,
    output logic [31:0] wb_count_o
);
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;
    logic        miss_pending_q, miss_pending_d;

    // Next counts; a response while a miss is pending is the re-lookup, not a hit
    always_comb begin
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        wb_count_d     = wb_count_q;
        miss_pending_d = miss_pending_q;
        if (miss_evt_i) begin
            miss_pending_d = 1'b1;
        end else if (resp_evt_i) begin
            miss_pending_d = 1'b0;
        end
        if (resp_evt_i && !miss_pending_q && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_evt_i && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
        end
        if (wb_evt_i && wb_count_q != 32'hFFFF_FFFF) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_q    <= 32'd0;
            miss_count_q   <= 32'd0;
            wb_count_q     <= 32'd0;
            miss_pending_q <= 1'b0;
        end else begin
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            wb_count_q     <= wb_count_d;
            miss_pending_q <= miss_pending_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
    assign wb_count_o   = wb_count_q;
endmodule

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - L2 write-back/write-allocate sequencing FSM; L2_PERF_CNT_EN adds counters
module l2_cache_control
    import rv32i_types::*;
(
    input logic              clk,
    input logic              rst_n,
    l2_cache_control_if.master bus
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      wb_count
`endif
);
    l2_ctrl_state_t state_q, state_d;
    logic           req;
    logic           dirty_sel;
    logic           mem_resp_d;
    logic           idling_d;
    logic           alloc_d;
    logic           w_back_d;
    logic           pmem_read_d;
    logic           pmem_write_d;

    assign req       = bus.mem_read | bus.mem_write;
    assign dirty_sel = victim_dirty({bus.dirty3_out, bus.dirty2_out, bus.dirty1_out, bus.dirty0_out},
                                    bus.lru_out);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= L2_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus Moore strobes; mem_resp is the only Mealy output
    always_comb begin
        state_d      = state_q;
        mem_resp_d   = 1'b0;
        idling_d     = 1'b0;
        alloc_d      = 1'b0;
        w_back_d     = 1'b0;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
        unique case (state_q)
            L2_IDLE: begin
                idling_d = 1'b1;
                if (req) begin
                    if (bus.hit_any) begin
                        mem_resp_d = 1'b1;
                    end else if (dirty_sel) begin
                        state_d = L2_WRITEBACK;
                    end else begin
                        state_d = L2_ALLOCATE;
                    end
                end
            end
            L2_WRITEBACK: begin
                w_back_d     = 1'b1;
                pmem_write_d = 1'b1;
                if (bus.pmem_resp) begin
                    state_d = L2_ALLOCATE;
                end
            end
            L2_ALLOCATE: begin
                alloc_d     = 1'b1;
                pmem_read_d = 1'b1;
                if (bus.pmem_resp) begin
                    state_d = L2_IDLE;
                end
            end
            default: begin
                state_d = L2_IDLE;
            end
        endcase
    end

    assign bus.mem_resp   = mem_resp_d;
    assign bus.idling     = idling_d;
    assign bus.alloc      = alloc_d;
    assign bus.w_back     = w_back_d;
    assign bus.pmem_read  = pmem_read_d;
    assign bus.pmem_write = pmem_write_d;

`ifdef L2_PERF_CNT_EN
    l2_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .resp_evt_i   (mem_resp_d),
        .miss_evt_i   (state_q == L2_IDLE && req && !bus.hit_any),
        .wb_evt_i     (state_q == L2_WRITEBACK && bus.pmem_resp),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count),
        .wb_count_o   (wb_count)
    );
`endif
endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - directed table-driven bench for l2_cache_control
module tb_l2_cache_control;
    typedef struct {
        logic       rd;
        logic       wr;
        logic       hit;
        logic [3:0] dirty;
        logic [1:0] lru;
        logic       presp;
        logic [5:0] exp;
    } vec_t;

    // {idling, alloc, w_back, pmem_read, pmem_write, mem_resp}
    localparam logic [5:0] O_IDLE = 6'b100000;
    localparam logic [5:0] O_RESP = 6'b100001;
    localparam logic [5:0] O_ALOC = 6'b010100;
    localparam logic [5:0] O_WB   = 6'b001010;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[25];

`ifdef L2_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    always #5 clk = ~clk;

    l2_cache_control_if bus();

    l2_cache_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
`endif
    );

    function automatic vec_t mk(input logic rd, input logic wr, input logic hit,
                                input logic [3:0] dirty, input logic [1:0] lru,
                                input logic presp, input logic [5:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.hit = hit; v.dirty = dirty;
        v.lru = lru; v.presp = presp; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.idling, bus.alloc, bus.w_back, bus.pmem_read, bus.pmem_write, bus.mem_resp};
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic hit,
                         input logic [3:0] dirty, input logic [1:0] lru, input logic presp);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.hit_any    = hit;
        bus.dirty0_out = dirty[0];
        bus.dirty1_out = dirty[1];
        bus.dirty2_out = dirty[2];
        bus.dirty3_out = dirty[3];
        bus.lru_out    = lru;
        bus.pmem_resp  = presp;
    endtask

    initial begin
        // Idle, hit, then clean miss (victim way 2 clean while others dirty)
        vecs[0]  = mk(0, 0, 0, 4'b0000, 2'd0, 0, O_IDLE);
        vecs[1]  = mk(1, 0, 1, 4'b0000, 2'd0, 0, O_RESP);
        vecs[2]  = mk(0, 0, 0, 4'b0000, 2'd0, 0, O_IDLE);
        vecs[3]  = mk(1, 0, 0, 4'b1011, 2'd2, 0, O_IDLE);
        vecs[4]  = mk(1, 0, 0, 4'b1011, 2'd2, 0, O_ALOC);
        vecs[5]  = mk(1, 0, 0, 4'b1011, 2'd2, 0, O_ALOC);
        vecs[6]  = mk(1, 0, 0, 4'b1011, 2'd2, 1, O_ALOC);
        vecs[7]  = mk(1, 0, 1, 4'b1011, 2'd2, 0, O_RESP);
        vecs[8]  = mk(0, 0, 0, 4'b0000, 2'd0, 0, O_IDLE);
        // Dirty miss on way 1 (way 2 clean); hit_any in WRITEBACK must not respond
        vecs[9]  = mk(0, 1, 0, 4'b0010, 2'd1, 0, O_IDLE);
        vecs[10] = mk(0, 1, 1, 4'b0010, 2'd1, 0, O_WB);
        vecs[11] = mk(0, 1, 0, 4'b0010, 2'd1, 1, O_WB);
        vecs[12] = mk(0, 1, 0, 4'b0010, 2'd1, 0, O_ALOC);
        vecs[13] = mk(0, 1, 0, 4'b0010, 2'd1, 1, O_ALOC);
        vecs[14] = mk(0, 1, 1, 4'b0010, 2'd1, 0, O_RESP);
        vecs[15] = mk(0, 0, 0, 4'b0000, 2'd0, 0, O_IDLE);
        // Clean miss on way 3, request dropped during ALLOCATE; stray pmem_resp in IDLE
        vecs[16] = mk(1, 0, 0, 4'b0111, 2'd3, 0, O_IDLE);
        vecs[17] = mk(0, 0, 0, 4'b0111, 2'd3, 0, O_ALOC);
        vecs[18] = mk(0, 0, 0, 4'b0111, 2'd3, 0, O_ALOC);
        vecs[19] = mk(0, 0, 0, 4'b0111, 2'd3, 1, O_ALOC);
        vecs[20] = mk(0, 0, 0, 4'b0000, 2'd0, 1, O_IDLE);
        vecs[21] = mk(0, 0, 0, 4'b0000, 2'd0, 0, O_IDLE);
        // Read+write together on a hit, then a plain read hit
        vecs[22] = mk(1, 1, 1, 4'b0000, 2'd0, 0, O_RESP);
        vecs[23] = mk(1, 0, 1, 4'b0000, 2'd0, 0, O_RESP);
        vecs[24] = mk(0, 0, 0, 4'b0000, 2'd0, 0, O_IDLE);

        rst_n = 1'b0;
        drive(0, 0, 0, 4'b0000, 2'd0, 0);
        repeat (2) @(posedge clk);
        #4;
        check("reset_outputs", {26'd0, outs()}, {26'd0, O_IDLE});
`ifdef L2_PERF_CNT_EN
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
        check("reset_wb_count", wb_count, 32'd0);
`endif

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            drive(vecs[i].rd, vecs[i].wr, vecs[i].hit, vecs[i].dirty, vecs[i].lru, vecs[i].presp);
            #3;
            check($sformatf("step%0d_outputs", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
        end
`ifdef L2_PERF_CNT_EN
        check("hit_count_after_table", hit_count, 32'd2);
        check("miss_count_after_table", miss_count, 32'd3);
        check("wb_count_after_table", wb_count, 32'd1);
`endif

        // Reset the cycle after pmem_read rises
        @(posedge clk); #1;
        drive(1, 0, 0, 4'b0000, 2'd0, 0);
        #3 check("rst_seq_lookup", {26'd0, outs()}, {26'd0, O_IDLE});
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3 check("rst_seq_alloc", {26'd0, outs()}, {26'd0, O_ALOC});
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 4'b0000, 2'd0, 0);
        #3 check("rst_seq_idle", {26'd0, outs()}, {26'd0, O_IDLE});
        check("rst_seq_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
`ifdef L2_PERF_CNT_EN
        check("rst_seq_hit_count", hit_count, 32'd0);
        check("rst_seq_miss_count", miss_count, 32'd0);
        check("rst_seq_wb_count", wb_count, 32'd0);

        // Saturation of hit_count from a preloaded value
        force dut.u_perf.hit_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_perf.hit_count_q;
        check("sat_preload", hit_count, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        drive(1, 0, 1, 4'b0000, 2'd0, 0);
        #3 check("sat_hit1_resp", {26'd0, outs()}, {26'd0, O_RESP});
        @(posedge clk); #1;
        drive(0, 0, 0, 4'b0000, 2'd0, 0);
        #3 check("sat_after_hit1", hit_count, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(1, 0, 1, 4'b0000, 2'd0, 0);
        #3 check("sat_hit2_resp", {26'd0, outs()}, {26'd0, O_RESP});
        @(posedge clk); #1;
        drive(0, 0, 0, 4'b0000, 2'd0, 0);
        #3 check("sat_after_hit2", hit_count, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Sequencing FSM for the 4-way, 16-set, 256-bit-line L2 cache datapath. Sits between the L1 arbiter (requester side) and physical memory. It drives the datapath's `idling`, `alloc` and `w_back` strobes from the datapath's hit, dirty and LRU status, and handshakes both sides. It implements write-back/write-allocate: dirty-victim writeback, line fill, then re-lookup.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mem_read`  in  1  arbiter read request; held until `mem_resp`.
- `mem_write`  in  1  arbiter write request (256-bit line); held until `mem_resp`.
- `mem_resp`  out  1  one-cycle completion pulse to arbiter.
- `hit_any`  in  1  datapath: valid tag match in some way.
- `dirty0_out`..`dirty3_out`  in  1 each  datapath: dirty bit of way 0..3 at current index.
- `lru_out`  in  2  datapath: victim way.
- `idling`  out  1  datapath: lookup/hit-service phase; enables hit writes.
- `alloc`  out  1  datapath: line fill; selects `pmem_rdata`, writes valid=1 and dirty=0.
- `w_back`  out  1  datapath: writeback; selects victim tag for `pmem_address`.
- `pmem_read`  out  1  memory read request; held until `pmem_resp`.
- `pmem_write`  out  1  memory write request; held until `pmem_resp`.
- `pmem_resp`  in  1  memory one-cycle completion.
- `hit_count`, `miss_count`, `wb_count`  out  32 each  present only with `L2_PERF_CNT_EN`.

## Operation
- States: `IDLE`, `WRITEBACK`, `ALLOCATE`.
- `IDLE`:
  - `idling`=1.
  - With `req = mem_read | mem_write`:
    - `req & hit_any`: `mem_resp`=1 combinationally; the datapath writes the line and marks it dirty if `mem_write`, and updates LRU. Stay in `IDLE`.
    - `req & ~hit_any`: `victim_dirty = dirtyN_out` selected by `lru_out`. Next state is `WRITEBACK` if `victim_dirty`, else `ALLOCATE`.
  - No request: stay in `IDLE`, all other outputs 0.
- `WRITEBACK`:
  - `w_back`=1 and `pmem_write`=1 until `pmem_resp`.
  - On `pmem_resp`, go to `ALLOCATE`.
- `ALLOCATE`:
  - `alloc`=1 and `pmem_read`=1 until `pmem_resp`.
  - On `pmem_resp`, the datapath writes the fill into way `lru_out`. Go to `IDLE`; the re-lookup hits and responds.
- `mem_read` and `mem_write` both high: treated as a write (protocol violation, no error flag).
- Request dropped mid-miss: the pmem transaction completes anyway; no `mem_resp` is issued. The fill remains valid and clean.
- `idling`, `alloc` and `w_back` are one-hot or all-zero; never two high together.
- `mem_resp` is asserted only in `IDLE` with `hit_any`.
- `pmem_read`/`pmem_write` are never both high.

## Timing
- Reset values: state `IDLE`. `mem_resp`, `alloc`, `w_back`, `pmem_read`, `pmem_write` are 0. `idling`=1. Counters are 0.
- Outputs are a Moore decode of state, except `mem_resp`, which is Mealy (IDLE & req & hit_any).
- Hit: `mem_resp` in the same cycle the request is first seen (datapath arrays read combinationally).
- Clean miss: 1 lookup cycle, then `ALLOCATE` for N memory cycles, then 1 re-lookup cycle with `mem_resp`. Total N+2.
- Dirty miss: 1 + Nwb + Nfill + 1.
- `pmem_read`/`pmem_write` rise the cycle after the miss decision and fall the cycle after `pmem_resp`.
- Arbiter must drop or change its request the cycle after `mem_resp`. The controller does not filter a repeated request; it services it again.
- `rst_n` low during `WRITEBACK`/`ALLOCATE`: next edge forces `IDLE`, and `pmem_*` drop that cycle. Memory must tolerate an abandoned request.
- `pmem_resp` outside `WRITEBACK`/`ALLOCATE` is ignored.

## Configuration
`L2_PERF_CNT_EN` enables the performance counters.
- With the macro:
  - 32-bit saturating counters are instantiated and their ports exist.
  - `hit_count` increments on each `mem_resp` caused by a first-cycle hit only (re-lookup responses are not counted as hits).
  - `miss_count` increments on each `IDLE`→`WRITEBACK`/`ALLOCATE` transition.
  - `wb_count` increments on each `pmem_resp` in `WRITEBACK`.
  - Counters hold at 0xFFFF_FFFF and clear only on reset.
- Without the macro: no counter logic and no counter ports; FSM behaviour is identical.

## Structure
- Package `rv32i_types` gains `l2_ctrl_state_t`, a 2-bit enum {`L2_IDLE`, `L2_WRITEBACK`, `L2_ALLOCATE`}, shared with any cache debug monitor.
- A miss-pending flag is needed so re-lookup responses are excluded from `hit_count`. It is set on a miss and cleared on the next `mem_resp`.
- Sub-module `l2_perf_counters` holds the three saturating counters plus the miss-pending flag. It is instantiated only under `L2_PERF_CNT_EN`.

## Test plan
- Reset then `mem_read` with `hit_any`=1 → `mem_resp`=1 in the same cycle, `idling`=1, `pmem_read`=0; `hit_count`=1.
- Clean miss: `lru_out`=2, `dirty2_out`=0, memory responds 3 cycles after request → `alloc`/`pmem_read` high for 3 cycles; `mem_resp` on cycle 5 with the forced hit; `miss_count`=1, `wb_count`=0.
- Dirty miss: `lru_out`=1, `dirty1_out`=1 (`dirty2_out`=0, so the mux is checked) → `w_back`+`pmem_write` until `pmem_resp`, then `alloc`+`pmem_read`, then `mem_resp`; `wb_count`=1.
- Reset asserted the cycle after `pmem_read` rises → next cycle state `IDLE`, `pmem_read`=0, `idling`=1, all counters 0.
- Request dropped during `ALLOCATE` → `pmem_read` held until `pmem_resp`, then `IDLE` with no `mem_resp`. Both `mem_read`+`mem_write` on a hit → one `mem_resp`, dirty write path exercised.
- Counter saturation (preload via force to 0xFFFF_FFFE) → two hits leave `hit_count`=0xFFFF_FFFF.
